nco_phase_recover: RTL and testbench

Iterative CORDIC vectoring block that sits downstream of the NCO sin/cos generator. It accepts one `(fsin, fcos)` sample pair and returns the phase angle in NCO phase-accumulator units, plus the un-normalised magnitude. It also returns the phase difference from the previous sample, which recovers the NCO's `phi_inc` for loopback checking and frequency estimation. Throughput is one sample per `ITER+2` enabled cycles.

---
 rtl/nco_cordic_pkg.sv | 47 ++++
 rtl/nco_cordic_iter.sv | 48 ++++
 rtl/nco_phase_recover.sv | 149 ++++++++++++++
 tb/tb_nco_phase_recover.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_cordic_pkg.sv
// nco_cordic_pkg: arctangent table, rounding helper, FSM state encoding and
// gain constant shared by the CORDIC phase recovery block.
package nco_cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  // CORDIC gain K ~= 1.64676 in Q16; mag_o carries this factor uncorrected
  localparam int unsigned CORDIC_GAIN_Q16 = 32'd107922;
  localparam int unsigned ATAN_N          = 32'd24;

  // atan(2^-i) / 2pi * 2^32, rounded
  localparam logic [31:0] ATAN32 [0:23] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };

  // Rounding right-shift of the 32-bit table entry down to apr bits
  function automatic logic [31:0] atan_apr(input int unsigned i, input int unsigned apr);
    logic [32:0] sum;
    int unsigned sh;
    logic [31:0] res;
    res = 32'd0;
    sum = 33'd0;
    sh  = 32'd0;
    if ((i < ATAN_N) && (apr >= 32'd1) && (apr <= 32'd32)) begin
      sh = 32'd32 - apr;
      if (sh == 32'd0) begin
        res = ATAN32[i[4:0]];
      end else begin
        sum = {1'b0, ATAN32[i[4:0]]} + (33'd1 << (sh - 32'd1));
        res = 32'(sum >> sh);
      end
    end else begin
      res = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/nco_cordic_iter.sv
// nco_cordic_iter: one combinational CORDIC vectoring micro-rotation with a
// variable arithmetic shift selected by the iteration index.
module nco_cordic_iter
  import nco_cordic_pkg::*;
#(
  parameter int W   = 34,
  parameter int APR = 16
) (
  input  logic [W-1:0]   x_i,
  input  logic [W-1:0]   y_i,
  input  logic [APR-1:0] z_i,
  input  logic [4:0]     iter_i,
  output logic [W-1:0]   x_o,
  output logic [W-1:0]   y_o,
  output logic [APR-1:0] z_o
);

  logic [APR-1:0]      atan_tab_s [0:31];
  logic signed [W-1:0] x_sh_s;
  logic signed [W-1:0] y_sh_s;
  logic [APR-1:0]      atan_s;

  // Entries past the table end are zero so any 5-bit index is safe
  for (genvar g = 0; g < 32; g++) begin : g_atan
    assign atan_tab_s[g] = APR'(atan_apr(g, APR));
  end

  assign x_sh_s = $signed(x_i) >>> iter_i;
  assign y_sh_s = $signed(y_i) >>> iter_i;
  assign atan_s = atan_tab_s[iter_i];

  // Rotate toward y = 0 and accumulate the rotation angle into z
  always_comb begin
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (!y_i[W-1]) begin
      x_o = x_i + y_sh_s;
      y_o = y_i - x_sh_s;
      z_o = z_i + atan_s;
    end else begin
      x_o = x_i - y_sh_s;
      y_o = y_i + x_sh_s;
      z_o = z_i - atan_s;
    end
  end

endmodule

// File: rtl/nco_phase_recover.sv
// nco_phase_recover: iterative CORDIC vectoring that turns an NCO (sin, cos)
// pair into phase, uncompensated magnitude and sample-to-sample phase step.
// Optional feature macro: NCO_PHASE_RECOVER_INC_EN builds the phase-increment
// path; when undefined phi_inc_o is tied to zero.
module nco_phase_recover
  import nco_cordic_pkg::*;
#(
  parameter int MPR  = 32,
  parameter int APR  = 16,
  parameter int ITER = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MPR-1:0] fsin_i,
  input  logic [MPR-1:0] fcos_i,
  output logic [APR-1:0] phi_o,
  output logic [APR-1:0] phi_inc_o,
  output logic [MPR:0]   mag_o,
  output logic           out_valid
);

  // Two guard bits: one for the CORDIC gain, one so -2^(MPR-1) negates cleanly
  localparam int         W         = MPR + 2;
  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

  state_e         state_q;
  logic [4:0]     iter_q;
  logic [W-1:0]   x_q, y_q, x_d, y_d;
  logic [W-1:0]   x_ext_s, y_ext_s, x_ld_s, y_ld_s;
  logic [APR-1:0] z_q, z_d, z_ld_s, phi_res_s, phi_q;
  logic [MPR:0]   mag_q;
  logic           zero_q, in_ready_q, out_valid_q, last_s;

  assign x_ext_s = {{2{fcos_i[MPR-1]}}, fcos_i};
  assign y_ext_s = {{2{fsin_i[MPR-1]}}, fsin_i};

  // Left half-plane inputs are pre-rotated by pi so vectoring converges
  always_comb begin
    x_ld_s = x_ext_s;
    y_ld_s = y_ext_s;
    z_ld_s = {APR{1'b0}};
    if (x_ext_s[W-1]) begin
      x_ld_s = -x_ext_s;
      y_ld_s = -y_ext_s;
      z_ld_s = {1'b1, {(APR-1){1'b0}}};
    end else begin
      x_ld_s = x_ext_s;
      y_ld_s = y_ext_s;
      z_ld_s = {APR{1'b0}};
    end
  end

  nco_cordic_iter #(.W(W), .APR(APR)) u_iter (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .iter_i (iter_q),
    .x_o    (x_d),
    .y_o    (y_d),
    .z_o    (z_d)
  );

  assign last_s    = (iter_q == LAST_ITER);
  // A (0,0) input has no angle; report zero instead of the accumulated sweep
  assign phi_res_s = zero_q ? {APR{1'b0}} : z_d;

  // Control FSM, datapath registers and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      iter_q      <= 5'd0;
      x_q         <= {W{1'b0}};
      y_q         <= {W{1'b0}};
      z_q         <= {APR{1'b0}};
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      phi_q       <= {APR{1'b0}};
      mag_q       <= {(MPR+1){1'b0}};
    end else if (clken) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x_ld_s;
            y_q        <= y_ld_s;
            z_q        <= z_ld_s;
            zero_q     <= (fsin_i == {MPR{1'b0}}) && (fcos_i == {MPR{1'b0}});
            iter_q     <= 5'd0;
            in_ready_q <= 1'b0;
            state_q    <= ROT;
          end
        end
        ROT: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 5'd1;
          if (last_s) begin
            phi_q       <= phi_res_s;
            mag_q       <= x_d[MPR:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef NCO_PHASE_RECOVER_INC_EN
  logic [APR-1:0] prev_q, phi_inc_q;
  logic           first_q;

  // Phase step relative to the previous completed sample, modulo one turn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= {APR{1'b0}};
      phi_inc_q <= {APR{1'b0}};
      first_q   <= 1'b1;
    end else if (clken && (state_q == ROT) && last_s) begin
      phi_inc_q <= first_q ? {APR{1'b0}} : (phi_res_s - prev_q);
      prev_q    <= phi_res_s;
      first_q   <= 1'b0;
    end
  end

  assign phi_inc_o = phi_inc_q;
`else
  assign phi_inc_o = {APR{1'b0}};
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign phi_o     = phi_q;
  assign mag_o     = mag_q;

endmodule

// File: tb/tb_nco_phase_recover.sv
// tb_nco_phase_recover: randomized and directed checks of nco_phase_recover
// against an ideal atan2 / magnitude reference model.
module tb_nco_phase_recover;

  localparam int     MPR    = 32;
  localparam int     APR    = 16;
  localparam int     ITER   = 16;
  localparam longint PH_MOD = 65536;
  // Sum of per-entry table rounding errors plus final residual angle
  localparam longint PH_TOL = 4;
  localparam real    PI     = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset, clken, in_valid, in_ready, out_valid;
  logic [31:0] fsin_i, fcos_i;
  logic [15:0] phi_o, phi_inc_o;
  logic [32:0] mag_o;

  int     n_checks = 0;
  int     n_pass   = 0;
  real    k_gain;
  longint m_prev;
  bit     m_first;

  always #5 clk = ~clk;

  nco_phase_recover #(.MPR(MPR), .APR(APR), .ITER(ITER)) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fsin_i    (fsin_i),
    .fcos_i    (fcos_i),
    .phi_o     (phi_o),
    .phi_inc_o (phi_inc_o),
    .mag_o     (mag_o),
    .out_valid (out_valid)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp,
                           input longint tol, input longint modulus);
    longint d;
    d = obs - exp;
    if (modulus != 0) begin
      d = ((d % modulus) + modulus) % modulus;
      if (d > modulus / 2) d = d - modulus;
    end
    if (d < 0) d = -d;
    n_checks++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic longint ideal_phi(input logic [31:0] ys, input logic [31:0] xs);
    real y, x, a;
    longint r;
    y = real'($signed(ys));
    x = real'($signed(xs));
    if (x == 0.0 && y == 0.0) return 0;
    a = $atan2(y, x);
    if (a < 0.0) a = a + 2.0 * PI;
    r = longint'(a / (2.0 * PI) * 65536.0);
    if (r >= 65536) r = r - 65536;
    return r;
  endfunction

  function automatic longint ideal_mag(input logic [31:0] ys, input logic [31:0] xs);
    real y, x;
    y = real'($signed(ys));
    x = real'($signed(xs));
    return longint'($sqrt(x * x + y * y) * k_gain);
  endfunction

  task automatic nco_sample(input longint p, output logic [31:0] ys, output logic [31:0] xs);
    real th;
    th = real'(p) * 2.0 * PI / 65536.0;
    ys = 32'(longint'(1073741824.0 * $sin(th)));
    xs = 32'(longint'(1073741824.0 * $cos(th)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_first = 1'b1;
    m_prev  = 0;
  endtask

  task automatic do_sample(input logic [31:0] ys, input logic [31:0] xs,
                           input int stall, input string tag);
    int w, lat;
    longint ep, em, ei, ptol, itol;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check_val({tag, "_ready"}, longint'(in_ready), 1, 0, 0);
    fsin_i = ys; fcos_i = xs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (lat == 5 && stall > 0) begin
        clken = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        clken = 1'b1;
        lat += stall;
      end
      @(posedge clk); #1; lat++;
    end
    check_val({tag, "_lat"}, lat, ITER + 1 + stall, 0, 0);
    ep   = ideal_phi(ys, xs);
    ptol = (ys == 32'd0 && xs == 32'd0) ? 0 : PH_TOL;
    check_val({tag, "_phi"}, longint'(phi_o), ep, ptol, PH_MOD);
    em = ideal_mag(ys, xs);
    check_val({tag, "_mag"}, longint'(mag_o), em, em / 5000 + 64, 0);
`ifdef NCO_PHASE_RECOVER_INC_EN
    ei   = m_first ? 0 : ep - m_prev;
    itol = m_first ? 0 : 2 * PH_TOL;
`else
    ei   = 0;
    itol = 0;
`endif
    check_val({tag, "_inc"}, longint'(phi_inc_o), ei, itol, PH_MOD);
    if (stall > 0) begin
      clken = 1'b0;
      @(posedge clk); #1;
      check_val({tag, "_ovhold"}, longint'(out_valid), 1, 0, 0);
      clken = 1'b1;
    end
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, longint'(out_valid), 0, 0, 0);
    check_val({tag, "_idle"}, longint'(in_ready), 1, 0, 0);
    m_prev  = ep;
    m_first = 1'b0;
  endtask

  task automatic do_stream(input logic [31:0] ys, input logic [31:0] xs);
    int acc[3];
    int n, cyc, busy, w;
    longint ep;
    acc = '{0, 0, 0};
    n = 0; cyc = 0; busy = 0;
    fsin_i = ys; fcos_i = xs; in_valid = 1'b1;
    while (n < 3 && cyc < 200) begin
      if (in_ready === 1'b1) begin
        acc[n] = cyc;
        n++;
      end else if (n >= 1) begin
        busy++;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0;
    check_val("stream_cnt", n, 3, 0, 0);
    check_val("stream_gap1", acc[1] - acc[0], ITER + 2, 0, 0);
    check_val("stream_gap2", acc[2] - acc[1], ITER + 2, 0, 0);
    check_val("stream_busy", busy, 2 * (ITER + 1), 0, 0);
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check_val("stream_drain", longint'(in_ready), 1, 0, 0);
    ep = ideal_phi(ys, xs);
    check_val("stream_phi", longint'(phi_o), ep, PH_TOL, PH_MOD);
    // Identical consecutive samples give an exactly zero step
    check_val("stream_inc", longint'(phi_inc_o), 0, 0, PH_MOD);
    m_prev  = ep;
    m_first = 1'b0;
  endtask

  task automatic do_abort();
    int seen;
    fsin_i = 32'h2000_0000; fcos_i = 32'h2000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    seen = 0;
    @(posedge clk); #1;
    if (out_valid === 1'b1) seen = 1;
    reset = 1'b0;
    m_first = 1'b1;
    m_prev  = 0;
    repeat (ITER + 4) begin
      if (out_valid !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    check_val("abort_noval", seen, 0, 0, 0);
    check_val("abort_ready", longint'(in_ready), 1, 0, 0);
    check_val("abort_phi", longint'(phi_o), 0, 0, 0);
  endtask

  initial begin
    logic [31:0] ys, xs;
    reset = 1'b1; clken = 1'b1; in_valid = 1'b0;
    fsin_i = 32'd0; fcos_i = 32'd0;
    m_first = 1'b1; m_prev = 0;
    k_gain = 1.0;
    for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", longint'(in_ready), 1, 0, 0);
    check_val("rst_valid", longint'(out_valid), 0, 0, 0);
    check_val("rst_phi", longint'(phi_o), 0, 0, 0);
    check_val("rst_inc", longint'(phi_inc_o), 0, 0, 0);
    check_val("rst_mag", longint'(mag_o), 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_sample(32'h0000_0000, 32'h4000_0000, 0, "pos_x");
    do_sample(32'h4000_0000, 32'h0000_0000, 0, "pos_y");
    do_sample(32'h0000_0000, 32'h8000_0000, 0, "neg_x");
    do_sample(32'h0000_0000, 32'h0000_0000, 0, "zero");
    do_sample(32'hC000_0000, 32'h4000_0000, 0, "q4");

    // NCO loopback with a fixed phase increment of 0x0400
    do_reset();
    for (int k = 0; k < 10; k++) begin
      nco_sample(longint'(16'h0123) + k * 1024, ys, xs);
      do_sample(ys, xs, 0, "nco");
    end

    // Phase wrap-around between 0xFF00 and 0x0100
    nco_sample(longint'(16'hFF00), ys, xs);
    do_sample(ys, xs, 0, "wrap_a");
    nco_sample(longint'(16'h0100), ys, xs);
    do_sample(ys, xs, 0, "wrap_b");

    for (int k = 0; k < 40; k++) begin
      ys = $urandom;
      xs = $urandom;
      if ($signed(ys) > -32'sd16777216 && $signed(ys) < 32'sd16777216 &&
          $signed(xs) > -32'sd16777216 && $signed(xs) < 32'sd16777216)
        xs = 32'h1000_0000;
      do_sample(ys, xs, 0, "rand");
    end

    do_stream(32'h1234_5678, 32'hE000_0000);

    // Clock-enable gaps mid-rotation extend latency without changing results
    do_sample(32'h3000_0000, 32'hD800_0000, 0, "stall0");
    do_sample(32'h3000_0000, 32'hD800_0000, 3, "stall3");
    ys = $urandom; xs = 32'h2000_0000;
    do_sample(ys, xs, 2, "stall2");

    do_abort();
    do_sample(32'h1000_0000, 32'h0800_0000, 0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
